// File: rtl/cva5_multi_fifo_pkg.sv
// cva5_multi_fifo_pkg: width helpers shared by the multi-channel FIFO and its channel queues (no ports)
package cva5_multi_fifo_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/cva5_fifo_channel.sv
// cva5_fifo_channel: one FWFT queue with flush, status flags and occupancy (clk, rst, potential_push, push, pop, flush, data_in -> data_out, valid, full, almost_full, count)
module cva5_fifo_channel
  import cva5_multi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ALMOST_FULL_THRESHOLD = FIFO_DEPTH - 1,
  parameter int CHANNEL = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            potential_push,
  input  logic                            push,
  input  logic                            pop,
  input  logic                            flush,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            valid,
  output logic                            full,
  output logic                            almost_full,
  output logic [cnt_w(FIFO_DEPTH)-1:0]    count
);
  localparam int COUNT_W = cnt_w(FIFO_DEPTH);
  localparam int LOG2_DEPTH = ptr_w(FIFO_DEPTH);
  logic [COUNT_W-1:0] count_q, count_d;
  always_comb count_d = flush ? '0 : count_q + COUNT_W'(push) - COUNT_W'(pop);
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count = count_q;
  assign valid = count_q != '0;
  assign full = count_q == COUNT_W'(FIFO_DEPTH);
  assign almost_full = count_q >= COUNT_W'(ALMOST_FULL_THRESHOLD);
  if (FIFO_DEPTH == 1) begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    always_ff @(posedge clk) if (potential_push) data_q <= data_in;
    assign data_out = data_q;
  end else if (FIFO_DEPTH == 2) begin : g_shift
    logic [DATA_WIDTH-1:0] sr_q [2];
    always_ff @(posedge clk) begin
      if (push) begin
        sr_q[1] <= sr_q[0];
        sr_q[0] <= data_in;
      end
    end
    assign data_out = count_q[1] ? sr_q[1] : sr_q[0];
  end else begin : g_ram
    logic [LOG2_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
    always_comb begin
      rd_d = flush ? '0 : rd_q + LOG2_DEPTH'(pop);
      wr_d = flush ? '0 : wr_q + LOG2_DEPTH'(push);
    end
    always_ff @(posedge clk) begin
      rd_q <= rst ? '0 : rd_d;
      wr_q <= rst ? '0 : wr_d;
    end
    lutram_1w_1r #(.WIDTH(DATA_WIDTH), .DEPTH(2 ** LOG2_DEPTH)) u_ram (
      .clk(clk),
      .waddr_i(wr_q),
      .raddr_i(rd_q),
      .ram_write_i(potential_push),
      .ram_data_i(data_in),
      .ram_data_o(data_out)
    );
  end
  a_overflow: assert property (@(posedge clk) disable iff (rst) (push | potential_push) |-> (!full | pop))
    else $error("cva5_multi_fifo: push while full without pop on channel %0d", CHANNEL);
  a_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> valid)
    else $error("cva5_multi_fifo: pop while empty on channel %0d", CHANNEL);
  a_push_pp: assert property (@(posedge clk) disable iff (rst) push |-> potential_push)
    else $error("cva5_multi_fifo: push without potential_push on channel %0d", CHANNEL);
endmodule

// File: rtl/lutram_1w_1r.sv
// lutram_1w_1r: LUT RAM, one synchronous write port and one asynchronous read port (clk, waddr_i, raddr_i, ram_write_i, ram_data_i -> ram_data_o)
module lutram_1w_1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  input  logic                     ram_write_i,
  input  logic [WIDTH-1:0]         ram_data_i,
  output logic [WIDTH-1:0]         ram_data_o
);
  logic [WIDTH-1:0] ram_q [DEPTH];
  always_ff @(posedge clk) if (ram_write_i) ram_q[waddr_i] <= ram_data_i;
  assign ram_data_o = ram_q[raddr_i];
endmodule

// File: rtl/cva5_multi_fifo.sv
// cva5_multi_fifo: bank of NUM_CHANNELS independent FWFT queues (clk, rst, per-channel potential_push/push/pop/flush/data_in -> data_out/valid/full/almost_full/count)
module cva5_multi_fifo
  import cva5_multi_fifo_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ALMOST_FULL_THRESHOLD = FIFO_DEPTH - 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CHANNELS-1:0]                  potential_push,
  input  logic [NUM_CHANNELS-1:0]                  push,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]       data_in,
  input  logic [NUM_CHANNELS-1:0]                  pop,
  input  logic [NUM_CHANNELS-1:0]                  flush,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]       data_out,
  output logic [NUM_CHANNELS-1:0]                  valid,
  output logic [NUM_CHANNELS-1:0]                  full,
  output logic [NUM_CHANNELS-1:0]                  almost_full,
  output logic [NUM_CHANNELS*cnt_w(FIFO_DEPTH)-1:0] count
);
  localparam int COUNT_W = cnt_w(FIFO_DEPTH);
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    cva5_fifo_channel #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .ALMOST_FULL_THRESHOLD(ALMOST_FULL_THRESHOLD),
      .CHANNEL(c)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .potential_push(potential_push[c]),
      .push(push[c]),
      .pop(pop[c]),
      .flush(flush[c]),
      .data_in(data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .data_out(data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .valid(valid[c]),
      .full(full[c]),
      .almost_full(almost_full[c]),
      .count(count[c*COUNT_W +: COUNT_W])
    );
  end
endmodule
